// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_queue
//  Description : Reservation station and issue scheduler for the arithmetic
//                execute unit. A collapsing queue of dispatched ALU micro-ops
//                captures missing operands from the CDB by tag. The oldest
//                fully-ready entry moves into a registered valid/ready issue
//                port feeding the non-pipelined ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 64,
  parameter int OP_W   = 4
) (
  input  logic                         in_clk,
  input  logic                         in_rst_n,
  input  logic                         in_flush,
  input  logic                         in_disp_valid,
  output logic                         out_disp_ready,
  input  logic [OP_W-1:0]              in_disp_op,
  input  logic                         in_disp_set_cc,
  input  logic [TAG_W-1:0]             in_disp_tag,
  input  logic                         in_disp_a_rdy,
  input  logic [TAG_W-1:0]             in_disp_a_tag,
  input  logic [DATA_W-1:0]            in_disp_a_val,
  input  logic                         in_disp_b_rdy,
  input  logic [TAG_W-1:0]             in_disp_b_tag,
  input  logic [DATA_W-1:0]            in_disp_b_val,
  input  logic                         in_cdb_valid,
  input  logic [TAG_W-1:0]             in_cdb_tag,
  input  logic [DATA_W-1:0]            in_cdb_val,
  output logic                         out_iss_valid,
  input  logic                         in_iss_ready,
  output logic [OP_W-1:0]              out_iss_op,
  output logic                         out_iss_set_cc,
  output logic [TAG_W-1:0]             out_iss_tag,
  output logic [DATA_W-1:0]            out_iss_a,
  output logic [DATA_W-1:0]            out_iss_b,
  output logic [$clog2(DEPTH+1)-1:0]   out_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic              set_cc;
    logic [TAG_W-1:0]  tag;
    logic              a_rdy;
    logic [TAG_W-1:0]  a_tag;
    logic [DATA_W-1:0] a_val;
    logic              b_rdy;
    logic [TAG_W-1:0]  b_tag;
    logic [DATA_W-1:0] b_val;
  } entry_t;

  typedef enum logic [0:0] {
    ISS_EMPTY = 1'b0,
    ISS_FULL  = 1'b1
  } iss_state_t;

  // Slots [0, r_count) are valid; slot 0 is the oldest.
  entry_t            r_q     [DEPTH];
  entry_t            w_wk    [DEPTH];
  entry_t            w_q_nxt [DEPTH];
  entry_t            w_disp_ent;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic [CW-1:0]     w_wr_idx;
  logic [IW-1:0]     w_sel;
  logic              w_any_rdy;
  logic              w_take;
  logic              w_disp_fire;
  iss_state_t        r_state;
  iss_state_t        w_state_nxt;
  logic [OP_W-1:0]   r_iss_op;
  logic              r_iss_set_cc;
  logic [TAG_W-1:0]  r_iss_tag;
  logic [DATA_W-1:0] r_iss_a;
  logic [DATA_W-1:0] r_iss_b;

  assign out_disp_ready = (r_count != C_DEPTH) & ~in_flush;
  assign out_count      = r_count;
  assign out_iss_valid  = (r_state == ISS_FULL);
  assign out_iss_op     = r_iss_op;
  assign out_iss_set_cc = r_iss_set_cc;
  assign out_iss_tag    = r_iss_tag;
  assign out_iss_a      = r_iss_a;
  assign out_iss_b      = r_iss_b;

  assign w_disp_fire = in_disp_valid & out_disp_ready;
  // Select looks only at registered ready bits, so a wakeup this cycle issues next cycle.
  assign w_take      = w_any_rdy & ((r_state == ISS_EMPTY) | in_iss_ready);
  assign w_wr_idx    = r_count - CW'(w_take);
  assign w_count_nxt = r_count + CW'(w_disp_fire) - CW'(w_take);

  // Dispatch entry, capturing an operand from the same-cycle CDB when it is still pending.
  always_comb begin
    w_disp_ent        = '0;
    w_disp_ent.op     = in_disp_op;
    w_disp_ent.set_cc = in_disp_set_cc;
    w_disp_ent.tag    = in_disp_tag;
    w_disp_ent.a_tag  = in_disp_a_tag;
    w_disp_ent.b_tag  = in_disp_b_tag;
    w_disp_ent.a_rdy  = in_disp_a_rdy;
    w_disp_ent.a_val  = in_disp_a_val;
    w_disp_ent.b_rdy  = in_disp_b_rdy;
    w_disp_ent.b_val  = in_disp_b_val;
    if (!in_disp_a_rdy && in_cdb_valid && (in_disp_a_tag == in_cdb_tag)) begin
      w_disp_ent.a_rdy = 1'b1;
      w_disp_ent.a_val = in_cdb_val;
    end
    if (!in_disp_b_rdy && in_cdb_valid && (in_disp_b_tag == in_cdb_tag)) begin
      w_disp_ent.b_rdy = 1'b1;
      w_disp_ent.b_val = in_cdb_val;
    end
  end

  // CDB wakeup of stored entries and lowest-index ready selection.
  always_comb begin
    w_any_rdy = 1'b0;
    w_sel     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_wk[i] = r_q[i];
      if (in_cdb_valid && !r_q[i].a_rdy && (r_q[i].a_tag == in_cdb_tag)) begin
        w_wk[i].a_rdy = 1'b1;
        w_wk[i].a_val = in_cdb_val;
      end
      if (in_cdb_valid && !r_q[i].b_rdy && (r_q[i].b_tag == in_cdb_tag)) begin
        w_wk[i].b_rdy = 1'b1;
        w_wk[i].b_val = in_cdb_val;
      end
      if ((CW'(i) < r_count) && r_q[i].a_rdy && r_q[i].b_rdy) begin
        w_any_rdy = 1'b1;
        w_sel     = IW'(i);
      end
    end
  end

  // Collapse over the selected slot, then append any dispatch at the new tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_q_nxt[i] = w_wk[i];
      if (w_take && (IW'(i) >= w_sel)) begin
        w_q_nxt[i] = w_wk[(i == DEPTH - 1) ? i : i + 1];
      end
      if (w_disp_fire && (CW'(i) == w_wr_idx)) begin
        w_q_nxt[i] = w_disp_ent;
      end
    end
  end

  // Queue storage and occupancy; slots beyond r_count are don't-care after a flush.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else if (in_flush) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= w_q_nxt[i];
      end
    end
  end

  // Issue register state.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= ISS_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Issue register next state: fill when empty, drain or reload on ALU accept.
  always_comb begin
    w_state_nxt = r_state;
    if (in_flush) begin
      w_state_nxt = ISS_EMPTY;
    end else begin
      case (r_state)
        ISS_EMPTY: if (w_any_rdy) w_state_nxt = ISS_FULL;
        ISS_FULL:  if (in_iss_ready) w_state_nxt = w_any_rdy ? ISS_FULL : ISS_EMPTY;
        default:   w_state_nxt = ISS_EMPTY;
      endcase
    end
  end

  // Issue payload: loaded only on a take, so it holds steady while stalled.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_iss_op     <= '0;
      r_iss_set_cc <= 1'b0;
      r_iss_tag    <= '0;
      r_iss_a      <= '0;
      r_iss_b      <= '0;
    end else if (!in_flush && w_take) begin
      r_iss_op     <= r_q[w_sel].op;
      r_iss_set_cc <= r_q[w_sel].set_cc;
      r_iss_tag    <= r_q[w_sel].tag;
      r_iss_a      <= r_q[w_sel].a_val;
      r_iss_b      <= r_q[w_sel].b_val;
    end
  end

endmodule
`default_nettype wire
